// File: rtl/cache_snoop_ctrl_pkg.sv
// Shared coherence types for the two-core MSI bus and the snoop-side
// next-state rules used by the snoop responder.
package cache_snoop_ctrl_pkg;

  typedef enum logic [2:0] {
    NOOP         = 3'd0,
    READ_MISS_0  = 3'd1,
    READ_MISS_1  = 3'd2,
    WRITE_MISS_0 = 3'd3,
    WRITE_MISS_1 = 3'd4,
    INVALIDATE   = 3'd5
  } bus_op_t;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } cache_block_state_t;

  typedef enum logic [1:0] {
    SNP_IDLE  = 2'd0,
    SNP_CMP   = 2'd1,
    SNP_FLUSH = 2'd2,
    SNP_RESP  = 2'd3
  } snoop_state_t;

  typedef struct packed {
    cache_block_state_t next_state;
    logic               flush;
  } snoop_next_t;

  // True when the op was issued by the core that owns this snooper.
  function automatic logic bus_op_is_local(input bus_op_t op, input int core_id);
    logic is_local;
    case (op)
      READ_MISS_0, WRITE_MISS_0: is_local = (core_id == 32'sd0);
      READ_MISS_1, WRITE_MISS_1: is_local = (core_id == 32'sd1);
      default:                   is_local = 1'b0;
    endcase
    return is_local;
  endfunction

  // Next MSI state of a snooped line and whether it must be written back
  // first. A miss is expressed by passing INVALID as the current state.
  function automatic snoop_next_t msi_snoop_next(input bus_op_t op,
                                                 input cache_block_state_t st,
                                                 input int core_id);
    snoop_next_t r;
    r.next_state = st;
    r.flush      = 1'b0;
    if (bus_op_is_local(op, core_id)) begin
      r.next_state = st;
    end else begin
      case (op)
        READ_MISS_0, READ_MISS_1: begin
          if (st == MODIFIED) begin
            r.next_state = SHARED;
            r.flush      = 1'b1;
          end else begin
            r.next_state = st;
          end
        end
        WRITE_MISS_0, WRITE_MISS_1: begin
          r.next_state = INVALID;
          r.flush      = (st == MODIFIED);
        end
        INVALIDATE: begin
          // A MODIFIED line is dropped without write-back; the caller flags it.
          r.next_state = INVALID;
        end
        default: r.next_state = st;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_snoop_ctrl.sv
// Snoop responder beside one core's private direct-mapped cache: looks up a
// snooped address, writes back MODIFIED data when needed, updates the line
// state and acknowledges the bus transaction with a one-cycle done pulse.
module cache_snoop_ctrl
  import cache_snoop_ctrl_pkg::*;
#(
  parameter int CORE_ID = 0,
  parameter int IDX_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bus_req,
  input  bus_op_t              bus_op,
  input  logic [15:0]          bus_addr,
  output logic                 snp_done,
  output logic                 snp_hit,
  output logic                 snp_flush,
  output logic                 snp_err,
  output logic                 tag_rd_en,
  output logic [IDX_W-1:0]     tag_rd_idx,
  input  logic [16-IDX_W-1:0]  tag_rd_tag,
  input  cache_block_state_t   tag_rd_state,
  input  logic [15:0]          tag_rd_data,
  output logic                 st_wr_en,
  output logic [IDX_W-1:0]     st_wr_idx,
  output cache_block_state_t   st_wr_state,
  output logic                 wb_req,
  output logic [15:0]          wb_addr,
  output logic [15:0]          wb_data,
  input  logic                 wb_ack
);

  snoop_state_t       state_q, state_d;
  bus_op_t            op_q, op_d;
  logic [15:0]        addr_q, addr_d;
  logic [15:0]        data_q, data_d;
  logic               hit_q, hit_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;
  logic               served_q, served_d;
  cache_block_state_t nxt_q, nxt_d;

  logic               snp_done_q, snp_done_d;
  logic               snp_hit_q, snp_hit_d;
  logic               snp_flush_q, snp_flush_d;
  logic               snp_err_q, snp_err_d;
  logic               wb_req_q, wb_req_d;
  logic [15:0]        wb_addr_q, wb_addr_d;
  logic [15:0]        wb_data_q, wb_data_d;

  logic               tag_rd_en_s;
  logic               st_wr_en_s;
  cache_block_state_t st_wr_state_s;
  logic               lookup_hit_s;
  logic               lookup_err_s;
  snoop_next_t        lookup_nxt_s;

  // Tag compare and MSI decision on the data returned by the cache in CMP.
  always_comb begin
    lookup_hit_s = (tag_rd_tag == addr_q[15:IDX_W]) && (tag_rd_state != INVALID);
    lookup_nxt_s = msi_snoop_next(op_q, lookup_hit_s ? tag_rd_state : INVALID, CORE_ID);
    lookup_err_s = (op_q == INVALIDATE) && lookup_hit_s && (tag_rd_state == MODIFIED);
  end

  // Transaction FSM: accept, compare, optional write-back, respond.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    hit_d         = hit_q;
    flush_d       = flush_q;
    err_d         = err_q;
    nxt_d         = nxt_q;
    tag_rd_en_s   = 1'b0;
    st_wr_en_s    = 1'b0;
    st_wr_state_s = INVALID;
    case (state_q)
      SNP_IDLE: begin
        if (bus_req && !served_q) begin
          hit_d   = 1'b0;
          flush_d = 1'b0;
          err_d   = 1'b0;
          if ((bus_op != NOOP) && !bus_op_is_local(bus_op, CORE_ID)) begin
            tag_rd_en_s = 1'b1;
            op_d        = bus_op;
            addr_d      = bus_addr;
            state_d     = SNP_CMP;
          end else begin
            state_d = SNP_RESP;
          end
        end else begin
          state_d = SNP_IDLE;
        end
      end
      SNP_CMP: begin
        hit_d   = lookup_hit_s;
        flush_d = lookup_nxt_s.flush;
        err_d   = lookup_err_s;
        nxt_d   = lookup_nxt_s.next_state;
        data_d  = tag_rd_data;
        if (lookup_nxt_s.flush) begin
          state_d = SNP_FLUSH;
        end else begin
          // Only a real state change costs a write; a miss never writes.
          if (lookup_hit_s && (lookup_nxt_s.next_state != tag_rd_state)) begin
            st_wr_en_s    = 1'b1;
            st_wr_state_s = lookup_nxt_s.next_state;
          end else begin
            st_wr_en_s = 1'b0;
          end
          state_d = SNP_RESP;
        end
      end
      SNP_FLUSH: begin
        if (wb_ack) begin
          st_wr_en_s    = 1'b1;
          st_wr_state_s = nxt_q;
          state_d       = SNP_RESP;
        end else begin
          state_d = SNP_FLUSH;
        end
      end
      SNP_RESP: state_d = SNP_IDLE;
      default:  state_d = SNP_IDLE;
    endcase
  end

  // Served flag: blocks re-accepting the same held request until bus_req drops.
  always_comb begin
    if (state_q == SNP_RESP) begin
      served_d = 1'b1;
    end else if (!bus_req) begin
      served_d = 1'b0;
    end else begin
      served_d = served_q;
    end
  end

  // Next values of the registered outputs, derived from the next FSM state.
  always_comb begin
    snp_done_d  = (state_d == SNP_RESP);
    snp_hit_d   = snp_done_d & hit_d;
    snp_flush_d = snp_done_d & flush_d;
    snp_err_d   = snp_done_d & err_d;
    wb_req_d    = (state_d == SNP_FLUSH);
    wb_addr_d   = wb_req_d ? addr_d : 16'h0000;
    wb_data_d   = wb_req_d ? data_d : 16'h0000;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SNP_IDLE;
      op_q        <= NOOP;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      hit_q       <= 1'b0;
      flush_q     <= 1'b0;
      err_q       <= 1'b0;
      nxt_q       <= INVALID;
      served_q    <= 1'b0;
      snp_done_q  <= 1'b0;
      snp_hit_q   <= 1'b0;
      snp_flush_q <= 1'b0;
      snp_err_q   <= 1'b0;
      wb_req_q    <= 1'b0;
      wb_addr_q   <= 16'h0000;
      wb_data_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      hit_q       <= hit_d;
      flush_q     <= flush_d;
      err_q       <= err_d;
      nxt_q       <= nxt_d;
      served_q    <= served_d;
      snp_done_q  <= snp_done_d;
      snp_hit_q   <= snp_hit_d;
      snp_flush_q <= snp_flush_d;
      snp_err_q   <= snp_err_d;
      wb_req_q    <= wb_req_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Combinational strobes are held off while reset is asserted.
  assign tag_rd_en   = tag_rd_en_s & rst_n;
  assign tag_rd_idx  = tag_rd_en ? bus_addr[IDX_W-1:0] : {IDX_W{1'b0}};
  assign st_wr_en    = st_wr_en_s & rst_n;
  assign st_wr_idx   = st_wr_en ? addr_q[IDX_W-1:0] : {IDX_W{1'b0}};
  assign st_wr_state = st_wr_en ? st_wr_state_s : INVALID;

  assign snp_done  = snp_done_q;
  assign snp_hit   = snp_hit_q;
  assign snp_flush = snp_flush_q;
  assign snp_err   = snp_err_q;
  assign wb_req    = wb_req_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_cache_snoop_ctrl.sv
// Bench for cache_snoop_ctrl: a small cache/memory environment, directed
// cases from the snoop rules plus randomized ops against a reference model.
module tb_cache_snoop_ctrl;
  import cache_snoop_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               bus_req;
  bus_op_t            bus_op;
  logic [15:0]        bus_addr;
  logic               snp_done, snp_hit, snp_flush, snp_err;
  logic               tag_rd_en;
  logic [3:0]         tag_rd_idx;
  logic [11:0]        tag_rd_tag = 12'h000;
  cache_block_state_t tag_rd_state = INVALID;
  logic [15:0]        tag_rd_data = 16'h0000;
  logic               st_wr_en;
  logic [3:0]         st_wr_idx;
  cache_block_state_t st_wr_state;
  logic               wb_req;
  logic [15:0]        wb_addr, wb_data;
  logic               wb_ack;

  int total = 0;
  int bad   = 0;

  // Cache contents seen by the snooper.
  logic [11:0]        ln_tag [16];
  cache_block_state_t ln_st  [16];
  logic [15:0]        ln_data[16];

  // Observations of one transaction.
  int                 o_done, o_rd_cnt, o_wr_cnt, o_wr_cyc, o_wb_first, o_extra;
  logic [3:0]         o_rd_idx, o_wr_idx;
  cache_block_state_t o_wr_state;
  logic               o_hit, o_flush, o_err, o_wb_at_done;
  logic [15:0]        o_wb_addr, o_wb_data;

  typedef struct {
    bus_op_t            op;
    logic [15:0]        addr;
    logic [11:0]        ltag;
    cache_block_state_t lst;
    logic [15:0]        ldata;
    int                 ack_d;
  } case_t;

  cache_snoop_ctrl #(.CORE_ID(0), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_op(bus_op), .bus_addr(bus_addr),
    .snp_done(snp_done), .snp_hit(snp_hit), .snp_flush(snp_flush), .snp_err(snp_err),
    .tag_rd_en(tag_rd_en), .tag_rd_idx(tag_rd_idx), .tag_rd_tag(tag_rd_tag),
    .tag_rd_state(tag_rd_state), .tag_rd_data(tag_rd_data),
    .st_wr_en(st_wr_en), .st_wr_idx(st_wr_idx), .st_wr_state(st_wr_state),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // Cache read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (tag_rd_en) begin
      tag_rd_tag   <= ln_tag[tag_rd_idx];
      tag_rd_state <= ln_st[tag_rd_idx];
      tag_rd_data  <= ln_data[tag_rd_idx];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: outcome of a snoop from the MSI rules (bench runs CORE_ID=0).
  function automatic void ref_snoop(input bus_op_t op, input logic [11:0] ltag,
                                    input cache_block_state_t lst, input logic [15:0] addr,
                                    output bit remote, output bit hit, output bit flush,
                                    output bit err, output cache_block_state_t nst);
    remote = !(op == NOOP || op == READ_MISS_0 || op == WRITE_MISS_0);
    hit    = remote && (lst != INVALID) && (ltag == addr[15:4]);
    flush  = 1'b0;
    err    = 1'b0;
    nst    = lst;
    if (hit) begin
      if (op == READ_MISS_1 && lst == MODIFIED) begin flush = 1'b1; nst = SHARED; end
      if (op == WRITE_MISS_1) begin nst = INVALID; flush = (lst == MODIFIED); end
      if (op == INVALIDATE) begin nst = INVALID; err = (lst == MODIFIED); end
    end
  endfunction

  // Drive one op until snp_done (bounded), then one idle cycle with bus_req low.
  task automatic run_txn(input bus_op_t op, input logic [15:0] addr, input int ack_d,
                         input bit drop_req, input bit spur_ack);
    bit fin = 1'b0;
    o_done = -1; o_rd_cnt = 0; o_wr_cnt = 0; o_wr_cyc = -1; o_wb_first = -1; o_extra = 0;
    o_rd_idx = 4'h0; o_wr_idx = 4'h0; o_wr_state = INVALID;
    o_hit = 1'b0; o_flush = 1'b0; o_err = 1'b0; o_wb_at_done = 1'b0;
    o_wb_addr = 16'h0000; o_wb_data = 16'h0000;
    for (int c = 0; c < 40 && !fin; c++) begin
      if (wb_req && o_wb_first < 0) begin
        o_wb_first = c; o_wb_addr = wb_addr; o_wb_data = wb_data;
      end
      bus_req  = (drop_req && c >= 1) ? 1'b0 : 1'b1;
      bus_op   = op;
      bus_addr = addr;
      wb_ack   = (o_wb_first >= 0 && c == o_wb_first + ack_d) || (spur_ack && c <= 1);
      #2;
      if (tag_rd_en) begin o_rd_cnt++; o_rd_idx = tag_rd_idx; end
      if (st_wr_en) begin o_wr_cnt++; o_wr_cyc = c; o_wr_idx = st_wr_idx; o_wr_state = st_wr_state; end
      if (snp_done) begin
        o_done = c; o_hit = snp_hit; o_flush = snp_flush; o_err = snp_err;
        o_wb_at_done = wb_req; fin = 1'b1;
      end
      next_cycle();
    end
    bus_req = 1'b0;
    wb_ack  = 1'b0;
    #2;
    if (snp_done || tag_rd_en || st_wr_en) o_extra++;
    next_cycle();
  endtask

  task automatic test_reset();
    bus_req = 1'b1; bus_op = READ_MISS_1; bus_addr = 16'h0123; wb_ack = 1'b1;
    next_cycle();
    next_cycle();
    #2;
    total++; if (snp_done !== 1'b0) begin bad++; $display("FAIL rst_snp_done: got %b want 0", snp_done); end
    total++; if (snp_hit !== 1'b0) begin bad++; $display("FAIL rst_snp_hit: got %b want 0", snp_hit); end
    total++; if (snp_flush !== 1'b0) begin bad++; $display("FAIL rst_snp_flush: got %b want 0", snp_flush); end
    total++; if (snp_err !== 1'b0) begin bad++; $display("FAIL rst_snp_err: got %b want 0", snp_err); end
    total++; if (wb_req !== 1'b0) begin bad++; $display("FAIL rst_wb_req: got %b want 0", wb_req); end
    total++; if (wb_addr !== 16'h0000) begin bad++; $display("FAIL rst_wb_addr: got %h want 0000", wb_addr); end
    total++; if (wb_data !== 16'h0000) begin bad++; $display("FAIL rst_wb_data: got %h want 0000", wb_data); end
    total++; if (tag_rd_en !== 1'b0) begin bad++; $display("FAIL rst_tag_rd_en: got %b want 0", tag_rd_en); end
    total++; if (tag_rd_idx !== 4'h0) begin bad++; $display("FAIL rst_tag_rd_idx: got %h want 0", tag_rd_idx); end
    total++; if (st_wr_en !== 1'b0) begin bad++; $display("FAIL rst_st_wr_en: got %b want 0", st_wr_en); end
    total++; if (st_wr_idx !== 4'h0) begin bad++; $display("FAIL rst_st_wr_idx: got %h want 0", st_wr_idx); end
    total++; if (st_wr_state !== INVALID) begin bad++; $display("FAIL rst_st_wr_state: got %0d want 0", st_wr_state); end
    rst_n = 1'b1; bus_req = 1'b0; wb_ack = 1'b0;
    next_cycle();
  endtask

  task automatic test_snoop_ops();
    case_t dir[7];
    bus_op_t            ops[6] = '{NOOP, READ_MISS_0, READ_MISS_1, WRITE_MISS_0, WRITE_MISS_1, INVALIDATE};
    cache_block_state_t sts[3] = '{INVALID, SHARED, MODIFIED};
    dir[0] = '{READ_MISS_1,  16'h0123, 12'h012, MODIFIED, 16'hBEEF, 2};
    dir[1] = '{WRITE_MISS_1, 16'h0123, 12'h012, SHARED,   16'h1111, 0};
    dir[2] = '{READ_MISS_1,  16'h0123, 12'h013, MODIFIED, 16'h2222, 0};
    dir[3] = '{READ_MISS_0,  16'h0123, 12'h012, MODIFIED, 16'h3333, 0};
    dir[4] = '{NOOP,         16'h0123, 12'h012, MODIFIED, 16'h4444, 0};
    dir[5] = '{INVALIDATE,   16'h0123, 12'h012, MODIFIED, 16'h5555, 0};
    dir[6] = '{WRITE_MISS_1, 16'h0123, 12'h012, MODIFIED, 16'hCAFE, 0};
    for (int n = 0; n < 47; n++) begin
      case_t t;
      bit drop, spur, remote, hit, flush, err, wr;
      cache_block_state_t nst;
      int exp_done, exp_wb, exp_wr_cyc;
      if (n < 7) begin
        t = dir[n]; drop = 1'b0; spur = 1'b0;
      end else begin
        t.op    = ops[$urandom_range(0, 5)];
        t.addr  = 16'($urandom);
        t.ltag  = ($urandom_range(0, 2) != 0) ? t.addr[15:4] : 12'($urandom);
        t.lst   = sts[$urandom_range(0, 2)];
        t.ldata = 16'($urandom);
        t.ack_d = $urandom_range(0, 3);
        drop    = ($urandom_range(0, 3) == 0);
        spur    = ($urandom_range(0, 1) == 1);
      end
      ln_tag[t.addr[3:0]] = t.ltag; ln_st[t.addr[3:0]] = t.lst; ln_data[t.addr[3:0]] = t.ldata;
      ref_snoop(t.op, t.ltag, t.lst, t.addr, remote, hit, flush, err, nst);
      wr         = hit && (nst != t.lst);
      exp_done   = !remote ? 1 : (flush ? 3 + t.ack_d : 2);
      exp_wb     = flush ? 2 : -1;
      exp_wr_cyc = flush ? 2 + t.ack_d : 1;
      run_txn(t.op, t.addr, t.ack_d, drop, spur);
      total++; if (o_done != exp_done) begin bad++; $display("FAIL done_cycle[%0d]: got %0d want %0d", n, o_done, exp_done); end
      total++; if (o_hit !== hit) begin bad++; $display("FAIL snp_hit[%0d]: got %b want %b", n, o_hit, hit); end
      total++; if (o_flush !== flush) begin bad++; $display("FAIL snp_flush[%0d]: got %b want %b", n, o_flush, flush); end
      total++; if (o_err !== err) begin bad++; $display("FAIL snp_err[%0d]: got %b want %b", n, o_err, err); end
      total++; if (o_rd_cnt != (remote ? 1 : 0)) begin bad++; $display("FAIL tag_rd_count[%0d]: got %0d want %0d", n, o_rd_cnt, remote ? 1 : 0); end
      if (remote) begin
        total++; if (o_rd_idx !== t.addr[3:0]) begin bad++; $display("FAIL tag_rd_idx[%0d]: got %h want %h", n, o_rd_idx, t.addr[3:0]); end
      end
      total++; if (o_wr_cnt != (wr ? 1 : 0)) begin bad++; $display("FAIL st_wr_count[%0d]: got %0d want %0d", n, o_wr_cnt, wr ? 1 : 0); end
      if (wr) begin
        total++; if (o_wr_cyc != exp_wr_cyc) begin bad++; $display("FAIL st_wr_cycle[%0d]: got %0d want %0d", n, o_wr_cyc, exp_wr_cyc); end
        total++; if (o_wr_state !== nst) begin bad++; $display("FAIL st_wr_state[%0d]: got %0d want %0d", n, o_wr_state, nst); end
        total++; if (o_wr_idx !== t.addr[3:0]) begin bad++; $display("FAIL st_wr_idx[%0d]: got %h want %h", n, o_wr_idx, t.addr[3:0]); end
      end
      total++; if (o_wb_first != exp_wb) begin bad++; $display("FAIL wb_first_cycle[%0d]: got %0d want %0d", n, o_wb_first, exp_wb); end
      if (flush) begin
        total++; if (o_wb_addr !== t.addr) begin bad++; $display("FAIL wb_addr[%0d]: got %h want %h", n, o_wb_addr, t.addr); end
        total++; if (o_wb_data !== t.ldata) begin bad++; $display("FAIL wb_data[%0d]: got %h want %h", n, o_wb_data, t.ldata); end
      end
      total++; if (o_wb_at_done !== 1'b0) begin bad++; $display("FAIL wb_req_at_done[%0d]: got %b want 0", n, o_wb_at_done); end
      total++; if (o_extra != 0) begin bad++; $display("FAIL activity_after_done[%0d]: got %0d want 0", n, o_extra); end
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0, rd_cnt = 0, done_at = -1;
    ln_tag[3] = 12'h012; ln_st[3] = SHARED; ln_data[3] = 16'h7777;
    for (int c = 0; c < 5; c++) begin
      bus_req  = 1'b1;
      bus_op   = (c < 2) ? NOOP : READ_MISS_1;
      bus_addr = 16'h0123;
      wb_ack   = 1'b0;
      #2;
      if (snp_done) begin done_cnt++; done_at = c; end
      if (tag_rd_en) rd_cnt++;
      next_cycle();
    end
    total++; if (done_at != 1) begin bad++; $display("FAIL b2b_noop_done_cycle: got %0d want 1", done_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b2b_done_count_held: got %0d want 1", done_cnt); end
    total++; if (rd_cnt != 0) begin bad++; $display("FAIL b2b_accept_while_held: got %0d want 0", rd_cnt); end
    bus_req = 1'b0;
    next_cycle();
    run_txn(READ_MISS_1, 16'h0123, 0, 1'b0, 1'b0);
    total++; if (o_done != 2) begin bad++; $display("FAIL b2b_reaccept_done: got %0d want 2", o_done); end
    total++; if (o_hit !== 1'b1) begin bad++; $display("FAIL b2b_reaccept_hit: got %b want 1", o_hit); end
    total++; if (o_wr_cnt != 0) begin bad++; $display("FAIL b2b_reaccept_wr: got %0d want 0", o_wr_cnt); end
  endtask

  task automatic test_reset_mid_flush();
    int wr_cnt = 0, done_cnt = 0;
    logic wb_at2 = 1'b0;
    ln_tag[3] = 12'h012; ln_st[3] = MODIFIED; ln_data[3] = 16'hD00D;
    for (int c = 0; c < 5; c++) begin
      rst_n    = (c == 3) ? 1'b0 : 1'b1;
      bus_req  = (c < 4) ? 1'b1 : 1'b0;
      bus_op   = WRITE_MISS_1;
      bus_addr = 16'h0123;
      wb_ack   = 1'b0;
      #2;
      if (st_wr_en) wr_cnt++;
      if (snp_done) done_cnt++;
      if (c == 2) wb_at2 = wb_req;
      if (c == 4) begin
        total++; if (wb_req !== 1'b0) begin bad++; $display("FAIL rstf_wb_req: got %b want 0", wb_req); end
        total++; if (dut.state_q !== SNP_IDLE) begin bad++; $display("FAIL rstf_fsm_state: got %0d want 0", dut.state_q); end
        total++; if (tag_rd_en !== 1'b0) begin bad++; $display("FAIL rstf_tag_rd_en: got %b want 0", tag_rd_en); end
      end
      next_cycle();
    end
    total++; if (wb_at2 !== 1'b1) begin bad++; $display("FAIL rstf_wb_req_before: got %b want 1", wb_at2); end
    total++; if (wr_cnt != 0) begin bad++; $display("FAIL rstf_st_wr: got %0d want 0", wr_cnt); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rstf_done: got %0d want 0", done_cnt); end
    run_txn(WRITE_MISS_1, 16'h0123, 1, 1'b0, 1'b0);
    total++; if (o_done != 4) begin bad++; $display("FAIL rstf_retry_done: got %0d want 4", o_done); end
    total++; if (o_flush !== 1'b1) begin bad++; $display("FAIL rstf_retry_flush: got %b want 1", o_flush); end
    total++; if (o_wr_cyc != 3 || o_wr_state !== INVALID) begin bad++; $display("FAIL rstf_retry_wr: got cyc %0d st %0d want cyc 3 st 0", o_wr_cyc, o_wr_state); end
    total++; if (o_wb_data !== 16'hD00D) begin bad++; $display("FAIL rstf_retry_wb_data: got %h want d00d", o_wb_data); end
  endtask

  initial begin
    rst_n = 1'b0; bus_req = 1'b0; bus_op = NOOP; bus_addr = 16'h0000; wb_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ln_tag[i] = 12'h000; ln_st[i] = INVALID; ln_data[i] = 16'h0000;
    end
    test_reset();
    test_snoop_ops();
    test_back_to_back();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
